dpram_arbiter: RTL and testbench

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

---
 rtl/dpram_arbiter.sv | 139 +++++++++++++
 tb/tb_dpram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arbiter.sv
// Two-master write/read arbiter in front of a simple dual-port RAM with registered read data.
// Define DPRAM_ARB_RR_EN for round-robin on contention; otherwise master 0 has fixed priority.
module dpram_arbiter #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w0_req,
  input  logic [DEPTH-1:0] w0_addr,
  input  logic [WIDTH-1:0] w0_data,
  output logic             w0_ack,
  input  logic             w1_req,
  input  logic [DEPTH-1:0] w1_addr,
  input  logic [WIDTH-1:0] w1_data,
  output logic             w1_ack,
  input  logic             r0_req,
  input  logic [DEPTH-1:0] r0_addr,
  output logic             r0_ack,
  output logic             r0_valid,
  input  logic             r1_req,
  input  logic [DEPTH-1:0] r1_addr,
  output logic             r1_ack,
  output logic             r1_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             ram_we,
  output logic [DEPTH-1:0] ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic [DEPTH-1:0] ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata
);

  logic             w_req_any, w_sel;
  logic             r_req_any, r_sel;

  logic             ram_we_d, ram_we_q;
  logic [DEPTH-1:0] ram_waddr_d, ram_waddr_q;
  logic [WIDTH-1:0] ram_wdata_d, ram_wdata_q;
  logic [1:0]       w_ack_d, w_ack_q;
  logic [DEPTH-1:0] ram_raddr_d, ram_raddr_q;
  // Read pipeline: stage 1 is the ack cycle, stage 2 the data-valid cycle.
  logic             rd_v1_d, rd_v1_q, rd_tag1_d, rd_tag1_q;
  logic             rd_v2_d, rd_v2_q, rd_tag2_d, rd_tag2_q;
  logic [1:0]       r_ack_vec, r_valid_vec;

`ifdef DPRAM_ARB_RR_EN
  logic w_last_d, w_last_q;
  logic r_last_d, r_last_q;

  // On contention the master that did not win last time gets the grant.
  always_comb begin
    w_sel    = (w0_req && w1_req) ? ~w_last_q : ~w0_req;
    r_sel    = (r0_req && r1_req) ? ~r_last_q : ~r0_req;
    w_last_d = (w0_req || w1_req) ? w_sel : w_last_q;
    r_last_d = (r0_req || r1_req) ? r_sel : r_last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_last_q <= 1'b1;
      r_last_q <= 1'b1;
    end else begin
      w_last_q <= w_last_d;
      r_last_q <= r_last_d;
    end
  end
`else
  always_comb begin
    w_sel = ~w0_req;
    r_sel = ~r0_req;
  end
`endif

  always_comb begin
    w_req_any   = w0_req | w1_req;
    r_req_any   = r0_req | r1_req;

    ram_we_d    = w_req_any;
    w_ack_d     = w_req_any ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    if (w_req_any) begin
      ram_waddr_d = w_sel ? w1_addr : w0_addr;
      ram_wdata_d = w_sel ? w1_data : w0_data;
    end

    ram_raddr_d = ram_raddr_q;
    if (r_req_any) begin
      ram_raddr_d = r_sel ? r1_addr : r0_addr;
    end
    rd_v1_d   = r_req_any;
    rd_tag1_d = r_sel;
    rd_v2_d   = rd_v1_q;
    rd_tag2_d = rd_tag1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      w_ack_q     <= 2'b00;
      ram_raddr_q <= '0;
      rd_v1_q     <= 1'b0;
      rd_tag1_q   <= 1'b0;
      rd_v2_q     <= 1'b0;
      rd_tag2_q   <= 1'b0;
    end else begin
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      w_ack_q     <= w_ack_d;
      ram_raddr_q <= ram_raddr_d;
      rd_v1_q     <= rd_v1_d;
      rd_tag1_q   <= rd_tag1_d;
      rd_v2_q     <= rd_v2_d;
      rd_tag2_q   <= rd_tag2_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_decode
    assign r_ack_vec[gi]   = rd_v1_q & (rd_tag1_q == 1'(gi));
    assign r_valid_vec[gi] = rd_v2_q & (rd_tag2_q == 1'(gi));
  end

  assign w0_ack    = w_ack_q[0];
  assign w1_ack    = w_ack_q[1];
  assign r0_ack    = r_ack_vec[0];
  assign r1_ack    = r_ack_vec[1];
  assign r0_valid  = r_valid_vec[0];
  assign r1_valid  = r_valid_vec[1];
  assign ram_we    = ram_we_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_raddr = ram_raddr_q;
  // No write-to-read forwarding: data comes straight from the RAM's read port.
  assign rd_data   = ram_rdata;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: RAM model, transaction-level reference model, directed and random stimulus.
// Honours DPRAM_ARB_RR_EN to select round-robin or fixed-priority expectations.
module tb_dpram_arbiter;
  localparam int W = 9;
  localparam int D = 9;
  localparam int NWORDS = 1 << D;
`ifdef DPRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         w0_req = 0, w1_req = 0, r0_req = 0, r1_req = 0;
  logic [D-1:0] w0_addr = '0, w1_addr = '0, r0_addr = '0, r1_addr = '0;
  logic [W-1:0] w0_data = '0, w1_data = '0;
  logic         w0_ack, w1_ack, r0_ack, r1_ack, r0_valid, r1_valid;
  logic [W-1:0] rd_data, ram_wdata, ram_rdata;
  logic [D-1:0] ram_waddr, ram_raddr;
  logic         ram_we;

  always #5 clk = ~clk;

  dpram_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data), .w0_ack(w0_ack),
    .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data), .w1_ack(w1_ack),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_ack(r0_ack), .r0_valid(r0_valid),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_ack(r1_ack), .r1_valid(r1_valid),
    .rd_data(rd_data), .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] init_val(int a);
    if (a == 16) return 9'h0CC;
    return W'(a * 37 + 11);
  endfunction

  // Shared RAM: registered read, read-before-write on a same-address collision.
  logic [W-1:0] ram_mem [0:NWORDS-1];
  initial begin
    for (int a = 0; a < NWORDS; a++) ram_mem[a] = init_val(a);
    forever begin
      @(posedge clk);
      ram_rdata <= ram_mem[ram_raddr];
      if (ram_we) ram_mem[ram_waddr] = ram_wdata;
    end
  end

  // Reference model: per-edge grant decisions plus a queue of pending read completions.
  typedef struct {int due; bit m; logic [W-1:0] d;} rd_t;
  rd_t          rq[$];
  logic [W-1:0] mmem [0:NWORDS-1];
  int           cyc = 0;
  bit           m_wlast, m_rlast;
  logic         exp_we;
  logic [D-1:0] exp_waddr, exp_raddr;
  logic [W-1:0] exp_wdata;
  logic [1:0]   exp_wack, exp_rack;

  function automatic int pick(logic a, logic b, bit last);
    if (a && b) return (RR_EN && !last) ? 1 : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    rq.delete();
    exp_we = 0; exp_waddr = '0; exp_wdata = '0; exp_raddr = '0;
    exp_wack = 2'b00; exp_rack = 2'b00;
    m_wlast = 1; m_rlast = 1;
  endtask

  task automatic model_step();
    int g;
    cyc++;
    if (exp_we) mmem[exp_waddr] = exp_wdata;
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
    g = pick(w0_req, w1_req, m_wlast);
    exp_we = (g >= 0);
    exp_wack = 2'b00;
    if (g >= 0) begin
      exp_wack[g] = 1'b1;
      exp_waddr = (g == 1) ? w1_addr : w0_addr;
      exp_wdata = (g == 1) ? w1_data : w0_data;
      m_wlast = (g == 1);
    end
    g = pick(r0_req, r1_req, m_rlast);
    exp_rack = 2'b00;
    if (g >= 0) begin
      exp_rack[g] = 1'b1;
      exp_raddr = (g == 1) ? r1_addr : r0_addr;
      m_rlast = (g == 1);
      rq.push_back('{due: cyc + 1, m: (g == 1), d: mmem[exp_raddr]});
    end
  endtask

  initial begin
    for (int a = 0; a < NWORDS; a++) mmem[a] = init_val(a);
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    logic [1:0]   ev;
    logic [W-1:0] ed;
    forever begin
      @(negedge clk);
      ev = 2'b00;
      ed = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        ev[rq[0].m] = 1'b1;
        ed = rq[0].d;
      end
      chk("w_ack", {30'd0, w1_ack, w0_ack}, {30'd0, exp_wack});
      chk("ram_we", ram_we, exp_we);
      chk("ram_waddr", ram_waddr, exp_waddr);
      chk("ram_wdata", ram_wdata, exp_wdata);
      chk("r_ack", {30'd0, r1_ack, r0_ack}, {30'd0, exp_rack});
      if (!rst_n || exp_rack != 2'b00) chk("ram_raddr", ram_raddr, exp_raddr);
      chk("r_valid", {30'd0, r1_valid, r0_valid}, {30'd0, ev});
      if (ev != 2'b00) chk("rd_data", rd_data, ed);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    w0_req = 0; w1_req = 0; r0_req = 0; r1_req = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_reqs();
    repeat (2) tick();
    chk("rst_ram_we", ram_we, 0);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_acks", {w1_ack, w0_ack, r1_ack, r0_ack}, 0);
    chk("rst_valids", {r1_valid, r0_valid}, 0);
    rst_n = 1;
  endtask

  initial begin
    int nack, nval, nr0;
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nack, nval, nr0;
    do_reset();

    // Single write from master 0.
    w0_req = 1; w0_addr = 9'h005; w0_data = 9'h1AB;
    tick();
    w0_req = 0;
    chk("wr1_we", ram_we, 1);
    chk("wr1_waddr", ram_waddr, 9'h005);
    chk("wr1_wdata", ram_wdata, 9'h1AB);
    chk("wr1_w0_ack", w0_ack, 1);
    chk("wr1_w1_ack", w1_ack, 0);
    tick();
    chk("wr1_idle_we", ram_we, 0);
    chk("wr1_hold_waddr", ram_waddr, 9'h005);
    $display("txn single_write addr=005 data=1AB");

    // Write contention for four cycles.
    do_reset();
    w0_req = 1; w0_addr = 9'h020; w0_data = 9'h111;
    w1_req = 1; w1_addr = 9'h021; w1_data = 9'h122;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_w0_ack", w0_ack, RR_EN ? ((i % 2) == 0) : 1'b1);
      chk("cont_w1_ack", w1_ack, RR_EN ? ((i % 2) == 1) : 1'b0);
      $display("txn contention cycle=%0d w0_ack=%0b w1_ack=%0b", i, w0_ack, w1_ack);
    end
    clear_reqs();
    tick();

    // Read latency from master 1.
    do_reset();
    r1_req = 1; r1_addr = 9'h010;
    tick();
    r1_req = 0;
    chk("rlat_r1_ack", r1_ack, 1);
    chk("rlat_r0_ack", r0_ack, 0);
    chk("rlat_raddr", ram_raddr, 9'h010);
    tick();
    chk("rlat_r1_valid", r1_valid, 1);
    chk("rlat_rd_data", rd_data, 9'h0CC);
    chk("rlat_r0_valid", r0_valid, 0);
    $display("txn read_latency addr=010 data=%0h", rd_data);

    // Streaming reads from both masters.
    do_reset();
    r0_req = 1; r0_addr = 9'h030;
    r1_req = 1; r1_addr = 9'h031;
    nack = 0; nval = 0; nr0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 5) clear_reqs();
      nack += int'(r0_ack) + int'(r1_ack);
      nr0 += int'(r0_ack);
      nval += int'(r0_valid) + int'(r1_valid);
      $display("txn stream cycle=%0d r0_ack=%0b r1_ack=%0b r0_valid=%0b r1_valid=%0b rd_data=%0h",
               i, r0_ack, r1_ack, r0_valid, r1_valid, rd_data);
    end
    chk("stream_acks", nack, 6);
    chk("stream_valids", nval, 6);
    chk("stream_r0_acks", nr0, RR_EN ? 3 : 6);

    // Reset hits a read in flight.
    do_reset();
    r0_req = 1; r0_addr = 9'h040;
    tick();
    r0_req = 0;
    chk("rmid_r0_ack", r0_ack, 1);
    #2;
    rst_n = 0;
    #1;
    chk("rmid_ack_cleared", r0_ack, 0);
    chk("rmid_raddr", ram_raddr, 0);
    tick();
    chk("rmid_r0_valid", r0_valid, 0);
    chk("rmid_we", ram_we, 0);
    tick();
    chk("rmid_r0_valid2", r0_valid, 0);
    rst_n = 1;
    w0_req = 1; w0_addr = 9'h050; w0_data = 9'h0AA;
    w1_req = 1; w1_addr = 9'h051; w1_data = 9'h0BB;
    tick();
    clear_reqs();
    chk("rmid_first_w0", w0_ack, 1);
    chk("rmid_first_w1", w1_ack, 0);
    tick();
    $display("txn reset_mid_read done");

    // Randomised traffic with occasional asynchronous reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      w0_req = ($urandom_range(0, 9) < 6); w0_addr = D'($urandom_range(0, 31)); w0_data = W'($urandom);
      w1_req = ($urandom_range(0, 9) < 6); w1_addr = D'($urandom_range(0, 31)); w1_data = W'($urandom);
      r0_req = ($urandom_range(0, 9) < 6); r0_addr = D'($urandom_range(0, 31));
      r1_req = ($urandom_range(0, 9) < 6); r1_addr = D'($urandom_range(0, 31));
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        $display("txn random_reset cycle=%0d", i);
      end else begin
        tick();
      end
    end
    clear_reqs();
    repeat (3) tick();
    $display("txn random_traffic done cycles=3000");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
